// File: rtl/bp_pkg.sv
// Shared types and sizing for the branch history table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int IDX_W_DEF  = 4;
    localparam int CNT_W_DEF  = 2;
    localparam int STAT_W_DEF = 16;

    localparam int DEPTH    = 1 << IDX_W_DEF;
    localparam int CNT_MAX  = (1 << CNT_W_DEF) - 1;
    localparam int STAT_MAX = (1 << STAT_W_DEF) - 1;

endpackage

// File: rtl/sat_next.sv
// Saturating up/down step for one prediction counter.
// Latency: combinational.
// Backpressure: none.
module sat_next
    import bp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (taken && (cnt_in != '1)) begin
            cnt_out = cnt_in + 1'b1;
        end else if (!taken && (cnt_in != '0)) begin
            cnt_out = cnt_in - 1'b1;
        end
    end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table: saturating counters with one lookup and one update port.
// Latency: prediction 1 cycle after an accepted lookup; updates land on the next edge.
// Backpressure: lookup_ready low (busy) during the clear sweep; lookups and updates are dropped.
module bht_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              lookup_valid,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic              lookup_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_idx,
    input  logic              update_taken,
    input  logic              update_pred,
    output logic              busy,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int NUM_ENT = 1 << IDX_W;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   sweep_idx;
    logic [IDX_W-1:0]   sweep_idx_nxt;
    logic [CNT_W-1:0]   tbl [NUM_ENT];
    logic [CNT_W-1:0]   upd_cnt;
    logic               upd_en;
    logic               lookup_fire;
    logic               fwd_hit;

    assign busy         = (state == SWEEP);
    assign lookup_ready = ~busy;
    assign lookup_fire  = lookup_valid & ~busy;
    assign upd_en       = update_valid & ~busy;
    assign fwd_hit      = upd_en & (update_idx == lookup_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        case (state)
            SWEEP: begin
                if (flush) begin
                    sweep_idx_nxt = '0;
                end else if (&sweep_idx) begin
                    state_nxt     = RUN;
                    sweep_idx_nxt = '0;
                end else begin
                    sweep_idx_nxt = sweep_idx + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt     = SWEEP;
                    sweep_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt     = SWEEP;
                sweep_idx_nxt = '0;
            end
        endcase
    end

    sat_next #(
        .CNT_W (CNT_W)
    ) u_sat_next (
        .cnt_in  (tbl[update_idx]),
        .taken   (update_taken),
        .cnt_out (upd_cnt)
    );

    // Table has no reset; the sweep defines every entry before RUN.
    always_ff @(posedge clk) begin
        if (busy) begin
            tbl[sweep_idx] <= '0;
        end else if (upd_en) begin
            tbl[update_idx] <= upd_cnt;
        end
    end

    // Same-index update in the lookup cycle is forwarded so prediction sees the trained value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lookup_fire;
            if (lookup_fire) begin
                pred_taken <= fwd_hit ? upd_cnt[CNT_W-1] : tbl[lookup_idx][CNT_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispred_cnt <= '0;
        end else if (upd_en && (update_pred != update_taken) && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: sweep timing, saturation, forwarding, flush and mispredict stats.
module tb_bht_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [3:0]  lookup_idx = '0;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        update_valid = 1'b0;
    logic [3:0]  update_idx = '0;
    logic        update_taken = 1'b0;
    logic        update_pred = 1'b0;
    logic        busy;
    logic [15:0] mispred_cnt;

    int tests = 0;
    int fails = 0;

    bht_ctrl #(
        .IDX_W  (4),
        .CNT_W  (2),
        .STAT_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .lookup_valid (lookup_valid),
        .lookup_idx   (lookup_idx),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .update_valid (update_valid),
        .update_idx   (update_idx),
        .update_taken (update_taken),
        .update_pred  (update_pred),
        .busy         (busy),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [3:0] idx, input logic exp_taken, input string tag);
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        tick();
        lookup_valid = 1'b0;
        chk({tag, "_vld"}, 32'(pred_valid), 32'd1);
        chk({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken, input logic pred);
        update_valid = 1'b1;
        update_idx   = idx;
        update_taken = taken;
        update_pred  = pred;
        tick();
        update_valid = 1'b0;
    endtask

    // Counts busy cycles from the current sample while hammering both ports with
    // traffic that must be dropped (mismatching updates to idx 2, lookups of idx 2).
    task automatic sweep_len(output int n);
        int bad;
        n   = 0;
        bad = 0;
        lookup_valid = 1'b1;
        lookup_idx   = 4'd2;
        update_valid = 1'b1;
        update_idx   = 4'd2;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        while (busy && n < 200) begin
            if (n > 0 && pred_valid) bad++;
            if (lookup_ready) bad++;
            n++;
            tick();
        end
        if (pred_valid) bad++;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        chk("sweep_drop", 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int m;

        // Reset and initial sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(lookup_ready), 32'd0);
        chk("rst_pvld", 32'(pred_valid), 32'd0);
        chk("rst_ptaken", 32'(pred_taken), 32'd0);
        chk("rst_mispred", 32'(mispred_cnt), 32'd0);
        sweep_len(n);
        chk("init_sweep_len", 32'(n), 32'd16);
        chk("run_ready", 32'(lookup_ready), 32'd1);
        do_lookup(4'd9, 1'b0, "clear_lk9");
        chk("idle_pvld", 32'(pred_valid), 32'd1);
        tick();
        chk("pvld_drop", 32'(pred_valid), 32'd0);

        // idx 5 saturation both ends
        for (int i = 0; i < 4; i++) upd(4'd5, 1'b1, 1'b1);
        do_lookup(4'd5, 1'b1, "sat_hi");
        upd(4'd5, 1'b0, 1'b0);
        do_lookup(4'd5, 1'b1, "hi_minus1");
        upd(4'd5, 1'b0, 1'b0);
        do_lookup(4'd5, 1'b0, "hi_minus2");
        for (int i = 0; i < 3; i++) upd(4'd5, 1'b0, 1'b0);
        do_lookup(4'd5, 1'b0, "sat_lo");
        upd(4'd5, 1'b1, 1'b1);
        do_lookup(4'd5, 1'b0, "lo_plus1");

        // Forwarding on same-cycle lookup/update
        upd(4'd3, 1'b1, 1'b1);
        do_lookup(4'd3, 1'b0, "idx3_cnt1");
        update_valid = 1'b1;
        update_idx   = 4'd3;
        update_taken = 1'b1;
        update_pred  = 1'b1;
        do_lookup(4'd3, 1'b1, "fwd_same");
        update_valid = 1'b1;
        do_lookup(4'd4, 1'b0, "fwd_other");
        update_valid = 1'b0;
        do_lookup(4'd3, 1'b1, "idx3_after");
        chk("mispred_zero", 32'(mispred_cnt), 32'd0);

        // Flush from RUN with a lookup in the same cycle
        for (int i = 0; i < 3; i++) upd(4'd2, 1'b1, 1'b1);
        do_lookup(4'd2, 1'b1, "idx2_trained");
        flush        = 1'b1;
        lookup_valid = 1'b1;
        lookup_idx   = 4'd2;
        tick();
        flush        = 1'b0;
        lookup_valid = 1'b0;
        chk("flush_lk_vld", 32'(pred_valid), 32'd1);
        chk("flush_lk_taken", 32'(pred_taken), 32'd1);
        chk("flush_busy", 32'(busy), 32'd1);
        sweep_len(n);
        chk("flush_sweep_len", 32'(n), 32'd16);
        do_lookup(4'd2, 1'b0, "idx2_cleared");
        chk("sweep_upd_ignored", 32'(mispred_cnt), 32'd0);

        // Flush again during the 8th sweep cycle
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) n++;
            if (i == 7) flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        sweep_len(m);
        chk("reflush_len", 32'(n + m), 32'd24);

        // Mispredict statistic
        for (int i = 0; i < 15; i++) begin
            upd(4'(i), i[0], (i < 10) ? ~i[0] : i[0]);
        end
        chk("mispred_10", 32'(mispred_cnt), 32'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sweep_len(n);
        chk("mispred_flush_len", 32'(n), 32'd16);
        chk("mispred_keep", 32'(mispred_cnt), 32'd10);
        update_valid = 1'b1;
        update_idx   = 4'd7;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        for (int i = 0; i < 65525; i++) tick();
        update_valid = 1'b0;
        chk("mispred_max", 32'(mispred_cnt), 32'hFFFF);
        for (int i = 0; i < 3; i++) upd(4'd7, 1'b0, 1'b1);
        chk("mispred_sat", 32'(mispred_cnt), 32'hFFFF);

        // Reset mid-RUN with a lookup pending
        lookup_valid = 1'b1;
        lookup_idx   = 4'd7;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        lookup_valid = 1'b0;
        chk("rst2_pvld", 32'(pred_valid), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_mispred", 32'(mispred_cnt), 32'd0);
        sweep_len(n);
        chk("rst2_sweep_len", 32'(n), 32'd16);
        do_lookup(4'd7, 1'b0, "rst2_lk7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
